perceptron_mac: RTL and testbench
=================================

# perceptron_mac

Sequential signed fixed-point multiply-accumulate engine for the perceptron datapath. Computes y = bias + Σ x[i]·w[i] over N packed inputs, one product per clock, with a parametrised word width and fractional-bit count. It replaces the fixed 6-bit unsigned combinational multiply and add path with a start/done handshake unit. Output saturation is optional.

## Interface
Parameters:
- WIDTH, 6, word width of x, w, bias, y; signed two's complement, Q(WIDTH-FRAC).FRAC
- FRAC, 3, fractional bits; 0 ≤ FRAC < WIDTH
- N, 4, number of input/weight pairs; N ≥ 2

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a computation; sampled only in IDLE
- x_in  input  N*WIDTH  inputs; element i at [i*WIDTH +: WIDTH]
- w_in  input  N*WIDTH  weights, same packing as x_in
- bias  input  WIDTH  bias term, same Q format
- busy  output  1  high while a computation is in progress
- done  output  1  one-cycle pulse when y, fire and ovf are updated
- y  output  WIDTH  result, held until the next done
- fire  output  1  y > 0, strictly positive; registered with y
- ovf  output  1  the result did not fit in WIDTH bits; registered with y

## Operation
- FSM states: IDLE, ACCUM, FINISH.
- IDLE with start=1:
  - x_in, w_in and bias are latched into internal registers.
  - acc is loaded with sign-extended bias.
  - The index counter i is cleared to 0, busy is set to 1, and the FSM moves to ACCUM.
- ACCUM, each edge:
  - acc += (x[i]·w[i]) >>> FRAC.
  - The product is a full 2·WIDTH-bit signed value.
  - The shift is arithmetic, so it truncates toward −∞ (e.g. (−1·1)>>>3 = −1, (1·1)>>>3 = 0).
  - i increments. On the edge where i = N−1, the FSM moves to FINISH.
- FINISH, one edge:
  - y, fire and ovf are loaded.
  - done is pulsed, busy is cleared, and the FSM returns to IDLE.
- Accumulator width is ACC_W = 2·WIDTH + $clog2(N) + 1. The accumulator never wraps internally.
- ovf = 1 when acc lies outside [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- Latched operands are used for the whole computation, so input changes while busy have no effect.
- start is ignored while busy=1.

## Timing
- Reset values: busy=0, done=0, y=0, fire=0, ovf=0. The FSM is in IDLE, and acc, i and the operand registers are 0.
- start sampled at edge k:
  - busy is high after edge k.
  - Accumulation happens on edges k+1 … k+N.
  - done is high for the single cycle following edge k+N+1, and busy is low in that same cycle.
  - Latency is N+1 edges.
- Back-to-back: start may be asserted in the cycle where done=1. It is accepted at the next edge, with zero idle cycles between jobs.
- done is never high for two consecutive cycles unless a new start was accepted in between and N+1 more edges have elapsed. Minimum spacing between done pulses is N+2 edges.
- Reset asserted mid-operation:
  - All outputs and state return to their reset values immediately, without waiting for a clock edge.
  - No done pulse is produced for the aborted job.
  - The first start after reset deasserts behaves as from power-up.

## Configuration
- Macro: PERCEPTRON_MAC_SATURATE_EN.
- Defined: on overflow, y clamps to 2^(WIDTH−1)−1 if acc > 0, else to −2^(WIDTH−1).
- Undefined: y = acc[WIDTH−1:0], i.e. wrap-around truncation.
- In both builds ovf reports the overflow condition, and fire is computed from the final y.

## Test plan
WIDTH=6, FRAC=3, N=4 in all cases, so 1.0 = 8.
- Basic result: x={8,16,−8,4}, w={4,4,4,8}, bias=−4, start at edge 0.
  - Expect done only in the cycle after edge 5, y=8, fire=1, ovf=0.
  - Expect busy high after edges 0–4.
- Truncation: x={−1,0,0,0}, w={1,0,0,0}, bias=0 → y=−1 (6'h3F), fire=0, ovf=0. Then x={1,0,0,0}, w={1,0,0,0} → y=0, fire=0.
- Overflow: x={8,8,8,8}, w={8,8,8,8}, bias=0, giving acc=32.
  - With the macro defined: y=31, ovf=1, fire=1.
  - Without the macro: y=−32, ovf=1, fire=0.
- Handshake, part 1: pulse start again at edges 1–3 of a job and change x_in at edge 2. Expect exactly one done, with the result from the operands latched at edge 0.
- Handshake, part 2: assert start in the done cycle. Expect a second done exactly 6 edges later.
- Reset abort: assert reset between edges 2 and 3 of a job.
  - Expect busy=0, done=0, y=0 asynchronously, and no done afterwards.
  - A new job after reset release returns the correct result with latency 5.

Source files
------------

// File: rtl/perceptron_mac_if.sv
// Handshake and operand bundle for perceptron_mac: start/busy/done plus packed x/w/bias and the result.
interface perceptron_mac_if #(
  parameter int WIDTH = 6,
  parameter int N     = 4
);
  logic                 start;
  logic [N*WIDTH-1:0]   x_in;
  logic [N*WIDTH-1:0]   w_in;
  logic [WIDTH-1:0]     bias;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     y;
  logic                 fire;
  logic                 ovf;

  modport master (
    output start, x_in, w_in, bias,
    input  busy, done, y, fire, ovf
  );

  modport slave (
    input  start, x_in, w_in, bias,
    output busy, done, y, fire, ovf
  );
endinterface

// File: rtl/perceptron_mac.sv
// Sequential signed fixed-point MAC: y = bias + sum((x[i]*w[i]) >>> FRAC), one product per clock.
// Define PERCEPTRON_MAC_SATURATE_EN to clamp y on overflow instead of wrapping.
module perceptron_mac #(
  parameter int WIDTH = 6,
  parameter int FRAC  = 3,
  parameter int N     = 4
) (
  input  logic            clk,
  input  logic            reset,
  perceptron_mac_if.slave bus
);
  localparam int ACC_W = 2*WIDTH + $clog2(N) + 1;
  localparam int IDX_W = $clog2(N);
  localparam int PRD_W = 2*WIDTH;

  typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_t;

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [N*WIDTH-1:0]        x_q, x_d;
  logic [N*WIDTH-1:0]        w_q, w_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [WIDTH-1:0]          y_q, y_d;
  logic                      fire_q, fire_d;
  logic                      ovf_q, ovf_d;

  logic signed [WIDTH-1:0]   x_elem [N];
  logic signed [WIDTH-1:0]   w_elem [N];
  logic signed [PRD_W-1:0]   prod;
  logic signed [PRD_W-1:0]   prod_sh;
  logic [ACC_W-1:0]          acc_add;
  logic [ACC_W-WIDTH:0]      acc_upper;
  logic                      ovf_c;
  logic [WIDTH-1:0]          y_c;
  logic                      fire_c;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_elem
      assign x_elem[gi] = x_q[gi*WIDTH +: WIDTH];
      assign w_elem[gi] = w_q[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Full-width signed product; the arithmetic shift floors toward -inf.
  assign prod    = PRD_W'(x_elem[idx_q]) * PRD_W'(w_elem[idx_q]);
  assign prod_sh = prod >>> FRAC;
  assign acc_add = {{(ACC_W-PRD_W){prod_sh[PRD_W-1]}}, prod_sh};

  // The result fits iff every bit from WIDTH-1 upward equals the sign.
  assign acc_upper = acc_q[ACC_W-1:WIDTH-1];
  assign ovf_c     = !((&acc_upper) || !(|acc_upper));

`ifdef PERCEPTRON_MAC_SATURATE_EN
  assign y_c = !ovf_c         ? acc_q[WIDTH-1:0] :
               acc_q[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign y_c = acc_q[WIDTH-1:0];
`endif

  assign fire_c = !y_c[WIDTH-1] && (|y_c);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    x_d     = x_q;
    w_d     = w_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    y_d     = y_q;
    fire_d  = fire_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d     = bus.x_in;
          w_d     = bus.w_in;
          acc_d   = {{(ACC_W-WIDTH){bus.bias[WIDTH-1]}}, bus.bias};
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_q + acc_add;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(N-1)) state_d = FINISH;
      end
      FINISH: begin
        y_d     = y_c;
        fire_d  = fire_c;
        ovf_d   = ovf_c;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      x_q     <= '0;
      w_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      y_q     <= '0;
      fire_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      w_q     <= w_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      y_q     <= y_d;
      fire_q  <= fire_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.y    = y_q;
  assign bus.fire = fire_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_perceptron_mac.sv
// Directed bench for perceptron_mac with a result scoreboard; honours PERCEPTRON_MAC_SATURATE_EN.
module tb_perceptron_mac;
  localparam int WIDTH = 6;
  localparam int FRAC  = 3;
  localparam int N     = 4;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             fire;
    logic             ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  perceptron_mac_if #(.WIDTH(WIDTH), .N(N)) u_if ();

  perceptron_mac #(.WIDTH(WIDTH), .FRAC(FRAC), .N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   done_seen = 0;
  int   jobs = 0;
  int   cur_x [N];
  int   cur_w [N];
  int   cur_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ops(input int xs[N], input int ws[N], input int b);
    for (int i = 0; i < N; i++) begin
      cur_x[i] = xs[i];
      cur_w[i] = ws[i];
      u_if.x_in[i*WIDTH +: WIDTH] = WIDTH'(xs[i]);
      u_if.w_in[i*WIDTH +: WIDTH] = WIDTH'(ws[i]);
    end
    cur_b     = b;
    u_if.bias = WIDTH'(b);
  endtask

  // Integer reference: floor-divide each product by 2^FRAC, then range-check.
  function automatic exp_t model();
    exp_t e;
    int acc;
    logic signed [WIDTH-1:0] ys;
    acc = cur_b;
    for (int i = 0; i < N; i++) acc += (cur_x[i] * cur_w[i]) >>> FRAC;
    e.ovf = (acc > 31) || (acc < -32);
`ifdef PERCEPTRON_MAC_SATURATE_EN
    if (e.ovf) ys = (acc > 0) ? 6'sd31 : -6'sd32;
    else       ys = WIDTH'(acc);
`else
    ys = WIDTH'(acc);
`endif
    e.y    = ys;
    e.fire = (ys > 0);
    return e;
  endfunction

  task automatic start_job(input exp_t e);
    q.push_back(e);
    jobs++;
    u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
  endtask

  task automatic wait_done(input int lat);
    int  n = 0;
    bit  seen = 0;
    while (!seen && n < 20) begin
      tick();
      n++;
      if (u_if.done === 1'b1) seen = 1;
      else chk("busy_while_running", 32'(u_if.busy), 32'd1);
    end
    chk("done_latency", seen ? n : -1, lat);
    chk("busy_low_in_done", 32'(u_if.busy), 32'd0);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && u_if.done === 1'b1) begin
      exp_t e;
      done_seen++;
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        $display("job result y=%0h fire=%0b ovf=%0b exp y=%0h fire=%0b ovf=%0b",
                 u_if.y, u_if.fire, u_if.ovf, e.y, e.fire, e.ovf);
        chk("y", 32'(u_if.y), 32'(e.y));
        chk("fire", 32'(u_if.fire), 32'(e.fire));
        chk("ovf", 32'(u_if.ovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    exp_t e;
    reset      = 1'b1;
    u_if.start = 1'b0;
    u_if.x_in  = '0;
    u_if.w_in  = '0;
    u_if.bias  = '0;
    #1;
    chk("rst_busy", 32'(u_if.busy), 32'd0);
    chk("rst_done", 32'(u_if.done), 32'd0);
    chk("rst_y", 32'(u_if.y), 32'd0);
    chk("rst_fire", 32'(u_if.fire), 32'd0);
    chk("rst_ovf", 32'(u_if.ovf), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Basic result: 4 + 8 - 4 + 4 - 4 = 8
    set_ops('{8, 16, -8, 4}, '{4, 4, 4, 8}, -4);
    e = '{y: 6'd8, fire: 1'b1, ovf: 1'b0};
    start_job(e);
    chk("busy_after_start", 32'(u_if.busy), 32'd1);
    wait_done(5);
    tick();
    chk("done_single_cycle", 32'(u_if.done), 32'd0);

    // Truncation toward -inf
    set_ops('{-1, 0, 0, 0}, '{1, 0, 0, 0}, 0);
    e = '{y: 6'h3F, fire: 1'b0, ovf: 1'b0};
    start_job(e);
    wait_done(5);
    set_ops('{1, 0, 0, 0}, '{1, 0, 0, 0}, 0);
    e = '{y: 6'h00, fire: 1'b0, ovf: 1'b0};
    start_job(e);
    wait_done(5);

    // Overflow: acc = 32
    set_ops('{8, 8, 8, 8}, '{8, 8, 8, 8}, 0);
`ifdef PERCEPTRON_MAC_SATURATE_EN
    e = '{y: 6'd31, fire: 1'b1, ovf: 1'b1};
`else
    e = '{y: 6'h20, fire: 1'b0, ovf: 1'b1};
`endif
    start_job(e);
    wait_done(5);

    // Handshake: start held through edges 1-3, x_in changed before edge 2
    set_ops('{8, 16, -8, 4}, '{4, 4, 4, 8}, -4);
    q.push_back('{y: 6'd8, fire: 1'b1, ovf: 1'b0});
    jobs++;
    u_if.start = 1'b1;
    tick();
    tick();
    u_if.x_in = '1;
    tick();
    tick();
    u_if.start = 1'b0;
    wait_done(2);

    // Back-to-back start in the done cycle
    set_ops('{12, -20, 5, 31}, '{-7, 3, 9, 2}, 3);
    e = model();
    start_job(e);
    wait_done(5);

    // Reset abort between edges 2 and 3
    set_ops('{10, 10, 10, 10}, '{-3, 2, 1, 5}, 1);
    u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(u_if.busy), 32'd0);
    chk("abort_done", 32'(u_if.done), 32'd0);
    chk("abort_y", 32'(u_if.y), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("no_done_after_abort", 32'(u_if.done), 32'd0);
    end

    // Fresh job after reset, then random jobs
    set_ops('{10, 10, 10, 10}, '{-3, 2, 1, 5}, 1);
    e = model();
    start_job(e);
    wait_done(5);
    for (int r = 0; r < 6; r++) begin
      int xs [N];
      int ws [N];
      for (int i = 0; i < N; i++) begin
        xs[i] = int'($urandom_range(0, 63)) - 32;
        ws[i] = int'($urandom_range(0, 63)) - 32;
      end
      set_ops(xs, ws, int'($urandom_range(0, 63)) - 32);
      e = model();
      start_job(e);
      wait_done(5);
    end

    tick();
    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("done_count", 32'(done_seen), 32'(jobs));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
